delay_scheduler: RTL
====================

# delay_scheduler

Shares one programmable one-shot delay counter among `NUM_REQ` requesters. Each requester asks for a delayed strobe with its own cycle count. A round-robin arbiter grants the counter to one requester at a time, counts the delay and returns a one-cycle `done` strobe to that requester only. It sits beside the audio/keyboard sequencing logic and replaces per-channel delay instances with a single time-multiplexed counter.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `CNT_W`, 8: delay counter width; the maximum delay is 2^CNT_W-1.

- `clk` in, 1: single clock; all state updates on posedge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `req` in, `NUM_REQ`: per-requester level request; held high until `done` or abort.
- `delay_val` in, `NUM_REQ*CNT_W`: packed delays; slice i is `[i*CNT_W +: CNT_W]`.
- `grant` out, `NUM_REQ`: one-hot owner of the counter; all zero when idle.
- `done` out, `NUM_REQ`: one-hot, one-cycle completion strobe to the owner.
- `busy` out, 1: high in COUNT and DONE.
- `active_id` out, `$clog2(NUM_REQ)`: index of the current or last owner.

## Operation
- **States:** IDLE, COUNT, DONE. All outputs are registered.
- **IDLE:**
  - With any `req` high at a posedge: choose the winner round-robin, starting at `ptr+1` and wrapping modulo `NUM_REQ`.
  - At that edge: set `grant`, load `cnt <= delay_val[winner]`, set `ptr <= winner` and `active_id <= winner`, and go to COUNT.
  - With no `req` high: stay in IDLE.
- **COUNT:**
  - If `req[active_id]` is low, abort: go to IDLE, clear `grant`, no `done`.
  - Else if `cnt == 0`: go to DONE and assert `done[active_id]`.
  - Else: `cnt <= cnt - 1`.
  - Abort has priority over `cnt == 0` in the same cycle.
- **DONE:** go to IDLE unconditionally; clear `done` and `grant`.
- **Delay capture:** `delay_val` is sampled only at the grant edge. Later changes are ignored until the next grant.
- **Counter:** decrements with no wrap; it never goes below 0.
- **Re-request:** if the owner keeps `req` high after `done`, it counts as a new request. Round-robin still places it last among contenders.
- **Reset values:**
  - state IDLE, `grant` 0, `done` 0, `busy` 0, `active_id` 0, `cnt` 0.
  - `ptr` = `NUM_REQ-1`, so requester 0 wins first.
- **Reset mid-operation:** asserting `reset_n` low mid-operation drops `grant`, `busy` and `done` immediately (asynchronous). No `done` is issued for the interrupted request.

## Timing
- **Grant edge:** E0 is the edge at which IDLE samples `req`; `grant` and `busy` are high from E0.
- **Done strobe:** for delay D, `done` rises at edge E(D+1) and falls at E(D+2). That is one cycle wide, D+1 cycles after grant.
- **D = 0:** `done` rises at E1.
- **Release:** `grant` and `busy` fall at E(D+2). The earliest next grant is E(D+3), because IDLE lasts at least one cycle.
- **Back-to-back service period:** D+3 cycles per request under continuous contention.
- **Requester rule:** deassert `req` within one cycle of seeing `done`, i.e. registered on E(D+2).
- **Abort:** `req` sampled low at an edge during COUNT clears `grant` at that same edge.
- **Combinational paths:** none from inputs to outputs.

## Structure
- **Package `delay_sched_pkg`:** state enum (`ST_IDLE`, `ST_COUNT`, `ST_DONE`) and default `CNT_W`.
- **Sub-module `rr_arbiter`:** combinational round-robin pick. Inputs are `req` and `ptr`; outputs are winner index and `any`. Parameterised by `NUM_REQ`.
- **Top:** holds the FSM, `cnt`, `ptr` and output registers.

## Test plan
- **Single request:** after reset, `req[2]=1` with `delay_val[2]=5`, granted at E0 → `grant=4'b0100`, `done[2]` high only between E6 and E7, `busy` low after E7.
- **Zero delay:** `req[1]=1` with `delay=0` → `done[1]` at E1. A 255 delay with `CNT_W=8` → `done` at E256, no wrap.
- **Contention:** all four `req` high with `delay=2`, each requester dropping `req` after its `done` → grant order 0,1,2,3, with grants 5 cycles apart.
- **Fairness with a greedy owner:** `req[0]` held high permanently, `req[3]` high → grants alternate 0,3,0,3.
- **Abort:** `req[1]` dropped 3 cycles into a delay of 10 → `grant` clears at the next edge, no `done` ever, next requester granted one cycle later.
- **Reset mid-count:** `reset_n` pulsed low mid-count → outputs zero immediately. After release, requester 0 wins first; a `delay_val` change during COUNT does not affect the active count.

Source files
------------

// File: rtl/delay_scheduler_pkg.sv
// Shared types for the time-multiplexed delay scheduler.
package delay_sched_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last owner and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester after ptr is the final write.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[wrap_add(ptr, i)]) begin
        winner = wrap_add(ptr, i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// One programmable one-shot delay counter shared round-robin among NUM_REQ requesters.
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] delay_val,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [IDX_W-1:0]         active_id
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_active_id;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;

  logic [IDX_W-1:0]   w_winner;
  logic               w_any;
  logic [CNT_W-1:0]   w_delay;
  logic               w_owner_req;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .winner(w_winner),
    .any   (w_any)
  );

  assign w_delay     = delay_val[int'(w_winner)*CNT_W +: CNT_W];
  assign w_owner_req = req[r_active_id];

  // Abort is tested before the zero count so a dropped request never sees done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_active_id <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_COUNT;
            r_grant     <= NUM_REQ'(1) << w_winner;
            r_cnt       <= w_delay;
            r_ptr       <= w_winner;
            r_active_id <= w_winner;
            r_busy      <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (!w_owner_req) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_done  <= r_grant;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign busy      = r_busy;
  assign active_id = r_active_id;

endmodule
